// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: start/data/parity/stop bit timing, edge and bit counters, error checks.
// Latency: data_valid one cycle after the stop-bit end; no backpressure, the frame runs off the line timing.
module uart_rx_ctrl #(
    parameter int Data_width = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic [5:0] prescale,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    input  logic       sampled_bit,
    output logic       dat_samp_en,
    output logic       deser_en,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       data_valid,
    output logic       par_err,
    output logic       stop_err
);

    localparam logic [3:0] LastData = 4'(Data_width);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] edge_q, edge_d;
    logic [3:0] bit_q, bit_d;
    logic [5:0] presc_q, presc_d;
    logic       par_en_q, par_en_d;
    logic       par_typ_q, par_typ_d;
    logic       run_par_q, run_par_d;
    logic       par_err_q, par_err_d;
    logic       stop_err_q, stop_err_d;
    logic       dv_q, dv_d;
    logic       bit_end;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            edge_q     <= '0;
            bit_q      <= '0;
            presc_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            run_par_q  <= 1'b0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
            dv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_q     <= edge_d;
            bit_q      <= bit_d;
            presc_q    <= presc_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            run_par_q  <= run_par_d;
            par_err_q  <= par_err_d;
            stop_err_q <= stop_err_d;
            dv_q       <= dv_d;
        end
    end

    // Bit boundaries use the prescale captured at frame start, never the live input.
    assign bit_end = (edge_q == presc_q - 6'd1);

    always_comb begin
        state_d    = state_q;
        edge_d     = edge_q;
        bit_d      = bit_q;
        presc_d    = presc_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        run_par_d  = run_par_q;
        par_err_d  = par_err_q;
        stop_err_d = stop_err_q;
        dv_d       = 1'b0;

        if (state_q != IDLE) begin
            edge_d = bit_end ? 6'd0 : edge_q + 6'd1;
        end

        case (state_q)
            IDLE: begin
                edge_d = '0;
                bit_d  = '0;
                if (!RX_IN) begin
                    state_d    = START;
                    presc_d    = prescale;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    run_par_d  = 1'b0;
                    par_err_d  = 1'b0;
                    stop_err_d = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    if (!sampled_bit) begin
                        state_d = DATA;
                        bit_d   = 4'd1;
                    end else begin
                        state_d = IDLE;
                        bit_d   = '0;
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    run_par_d = run_par_q ^ sampled_bit;
                    if (bit_q < LastData) begin
                        bit_d = bit_q + 4'd1;
                    end else begin
                        bit_d   = LastData + 4'd1;
                        state_d = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    par_err_d = (sampled_bit != (run_par_q ^ par_typ_q));
                    bit_d     = LastData + 4'd2;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    stop_err_d = ~sampled_bit;
                    dv_d       = sampled_bit & ~par_err_q;
                    bit_d      = '0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                edge_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    assign dat_samp_en = (state_q != IDLE);
    assign deser_en    = (state_q == DATA);
    assign edge_cnt    = edge_q;
    assign bit_cnt     = bit_q;
    assign data_valid  = dv_q;
    assign par_err     = par_err_q;
    assign stop_err    = stop_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: table of frames with a data_valid scoreboard, plus reset and glitch sequences.
module tb_uart_rx_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       sampled_bit;
    logic       dat_samp_en;
    logic       deser_en;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       data_valid;
    logic       par_err;
    logic       stop_err;

    uart_rx_ctrl #(.Data_width(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .prescale   (prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .sampled_bit(sampled_bit),
        .dat_samp_en(dat_samp_en),
        .deser_en   (deser_en),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stop_err   (stop_err)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int sb_q[$];
    int mon_exp;

    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct packed {
        logic [5:0] presc;
        logic       par_en;
        logic       par_typ;
        logic [7:0] data;
        logic       par_bit;
        logic       stop_bit;
        logic       scram;
        logic       b2b;
        logic       exp_dv;
        logic       exp_pe;
        logic       exp_se;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    // Every data_valid pulse must match the oldest pending good frame, on the exact cycle.
    always @(negedge CLK) begin
        if (data_valid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL dv_unexpected: data_valid=1 at cycle %0d, required 0", cyc);
            end else begin
                mon_exp = sb_q.pop_front();
                if (cyc != mon_exp || par_err !== 1'b0 || stop_err !== 1'b0) begin
                    errors++;
                    $display("FAIL dv_timing: cycle %0d pe=%b se=%b, required cycle %0d pe=0 se=0",
                             cyc, par_err, stop_err, mon_exp);
                end
            end
        end
    end

    function automatic logic [14:0] outs();
        return {dat_samp_en, deser_en, edge_cnt, bit_cnt, data_valid, par_err, stop_err};
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        logic        bits[0:10];
        int          nb;
        int          p;
        int          b;
        int          e;
        int          bad;
        int          first_j;
        logic        pe_now;
        logic [14:0] want;
        logic [14:0] first_got;
        logic [14:0] first_want;
        nb = v.par_en ? 11 : 10;
        p  = int'(v.presc);
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = v.data[i];
        bits[9]  = v.par_en ? v.par_bit : v.stop_bit;
        bits[10] = v.par_en ? v.stop_bit : 1'b1;
        prescale    = v.presc;
        PAR_EN      = v.par_en;
        PAR_TYP     = v.par_typ;
        RX_IN       = 1'b0;
        sampled_bit = 1'b0;
        if (v.exp_dv) sb_q.push_back(cyc + 1 + nb * p);
        bad = 0;
        first_j = -1;
        first_got = '0;
        first_want = '0;
        for (int j = 0; j < nb * p; j++) begin
            @(negedge CLK);
            b = j / p;
            e = j % p;
            pe_now = (v.par_en && b == nb - 1) ? v.exp_pe : 1'b0;
            want = {1'b1, (b >= 1 && b <= 8), 6'(e), 4'(b), 1'b0, pe_now, 1'b0};
            if (outs() !== want) begin
                if (bad == 0) begin
                    first_j = j;
                    first_got = outs();
                    first_want = want;
                end
                bad++;
            end
            RX_IN       = bits[b];
            sampled_bit = bits[b];
            if (v.scram && j == p + 2) begin
                prescale = (p == 8) ? 6'd32 : 6'd8;
                PAR_EN   = ~v.par_en;
                PAR_TYP  = ~v.par_typ;
            end
        end
        @(negedge CLK);
        RX_IN       = 1'b1;
        sampled_bit = 1'b1;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL trace vec%0d: %0d bad cycles, first j=%0d got %h required %h",
                     idx, bad, first_j, first_got, first_want);
        end
        checks++;
        want = {1'b0, 1'b0, 6'd0, 4'd0, v.exp_dv, v.exp_pe, v.exp_se};
        if (outs() !== want) begin
            errors++;
            $display("FAIL frame_end vec%0d: got %h required %h", idx, outs(), want);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] mid_dat;
        int         gbad;
        //           presc  pen   ptyp  data   pbit  stop  scr   b2b   dv    pe    se
        vecs[0]  = '{6'd8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{6'd16, 1'b1, 1'b0, 8'h37, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{6'd16, 1'b1, 1'b0, 8'h37, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{6'd16, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{6'd16, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{6'd8,  1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{6'd32, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{6'd8,  1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{6'd16, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{6'd16, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{6'd8,  1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        RST         = 1'b1;
        RX_IN       = 1'b1;
        sampled_bit = 1'b1;
        prescale    = 6'd8;
        PAR_EN      = 1'b0;
        PAR_TYP     = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (outs() !== 15'd0) begin
            errors++;
            $display("FAIL reset_state: got %h required 0", outs());
        end
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        for (int i = 0; i < NV; i++) begin
            run_vec(i, vecs[i]);
            if (!vecs[i].b2b) begin
                repeat (3) @(negedge CLK);
                checks++;
                if ({par_err, stop_err} !== {vecs[i].exp_pe, vecs[i].exp_se}) begin
                    errors++;
                    $display("FAIL flag_hold vec%0d: got pe=%b se=%b required pe=%b se=%b",
                             i, par_err, stop_err, vecs[i].exp_pe, vecs[i].exp_se);
                end
            end
        end

        // Held error flags are wiped by reset.
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (outs() !== 15'd0) begin
            errors++;
            $display("FAIL reset_flags: got %h required 0", outs());
        end
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // Start glitch: line low for three cycles, sampler reports 1 at the bit end.
        prescale    = 6'd8;
        PAR_EN      = 1'b0;
        RX_IN       = 1'b0;
        sampled_bit = 1'b1;
        gbad = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge CLK);
            if (outs() !== {1'b1, 1'b0, 6'(j), 4'd0, 3'b000}) gbad++;
            if (j == 2) RX_IN = 1'b1;
        end
        checks++;
        if (gbad != 0) begin
            errors++;
            $display("FAIL glitch_trace: %0d bad cycles, required 0", gbad);
        end
        @(negedge CLK);
        checks++;
        if (outs() !== 15'd0) begin
            errors++;
            $display("FAIL glitch_idle: got %h required 0", outs());
        end
        repeat (3) @(negedge CLK);

        // Reset in the middle of data bit 4, then a clean frame.
        mid_dat     = 8'h0F;
        prescale    = 6'd16;
        PAR_EN      = 1'b0;
        RX_IN       = 1'b0;
        sampled_bit = 1'b0;
        for (int j = 0; j < 4 * 16 + 3; j++) begin
            @(negedge CLK);
            if (j == 4 * 16 + 2) begin
                checks++;
                if (bit_cnt !== 4'd4 || deser_en !== 1'b1) begin
                    errors++;
                    $display("FAIL mid_frame_pos: bit_cnt=%0d deser_en=%b required 4 and 1",
                             bit_cnt, deser_en);
                end
            end else begin
                RX_IN       = (j / 16 == 0) ? 1'b0 : mid_dat[j/16 - 1];
                sampled_bit = RX_IN;
            end
        end
        RST         = 1'b1;
        RX_IN       = 1'b1;
        sampled_bit = 1'b1;
        @(negedge CLK);
        checks++;
        if (outs() !== 15'd0) begin
            errors++;
            $display("FAIL mid_frame_reset: got %h required 0", outs());
        end
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (dat_samp_en !== 1'b0 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: dat_samp_en=%b data_valid=%b required 0 0",
                     dat_samp_en, data_valid);
        end
        run_vec(NV, '{6'd16, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        repeat (3) @(negedge CLK);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL dv_missing: %0d frames without data_valid, required 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
